peripheral_bcd2bin: RTL
=======================

PERIPHERAL_BCD2BIN -- requirements
Module: peripheral_bcd2bin

Interface
REQ-001 The block SHALL have clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have rst, input, 1 bit: asynchronous reset, active-high.
REQ-003 The block SHALL have d_in, input, 16 bits: bus write data.
REQ-004 The block SHALL have cs, input, 1 bit: chip select; no access occurs when cs=0.
REQ-005 The block SHALL have addr, input, 4 bits: register address within the peripheral.
REQ-006 The block SHALL have rd, input, 1 bit: read strobe.
REQ-007 The block SHALL have wr, input, 1 bit: write strobe.
REQ-008 The block SHALL have d_out, output, 16 bits: read data.

Function
REQ-009 The address map SHALL be: 0x0 enable (W), 0x2 tho (R/W), 0x4 hun (R/W), 0x6 ten (R/W), 0x8 uni (R/W), 0xA result (R), 0xC done (R), 0xE err (R).
REQ-010 The block SHALL perform a write on a rising edge when cs=1 and wr=1; writes to the digit registers SHALL store d_in[3:0].
REQ-011 Writes to read-only or unmapped addresses SHALL be ignored.
REQ-012 The enable register SHALL store d_in[0]; a start SHALL occur only on a write that takes enable from 0 to 1 while the FSM is in IDLE or DONE.
REQ-013 The FSM SHALL have the states IDLE, CALC and DONE.
REQ-014 On start with all four digits <=9, the FSM SHALL enter CALC and clear acc, idx, done and err at the same edge.
REQ-015 Each CALC edge SHALL perform acc <= acc*10 + digit[idx] in the order tho, hun, ten, uni, then increment idx; the multiply SHALL be implemented as (acc<<3)+(acc<<1), with no multiplier.
REQ-016 After the 4th CALC edge, the FSM SHALL enter DONE, load result with the final acc zero-extended to 16 bits, and set done=1.
REQ-017 done SHALL be visible 5 rising edges after the start-write edge.
REQ-018 The maximum result SHALL be 9999 (0x270F), and no overflow SHALL be possible.
REQ-019 On start with any digit >9, the FSM SHALL go directly to DONE at the next edge with err=1, result=0 and done=1.
REQ-020 While in CALC, writes to the digit registers and the enable register SHALL be ignored; the enable register value is unchanged and no restart occurs.
REQ-021 done, err and result SHALL hold in DONE until the next start; a start SHALL clear done and err at the start edge.
REQ-022 Writing enable=0 SHALL only clear the enable register and SHALL NOT affect done, result or the FSM.
REQ-023 d_out SHALL be combinational: when cs=1 and rd=1, the addressed register zero-extended (done and err in bit 0, enable readback not supported); otherwise 16'h0000.
REQ-024 Reads of 0x0 and of unmapped addresses SHALL return 0.
REQ-025 When rd and wr are asserted together, the write SHALL occur at the edge, and d_out SHALL show the register's pre-edge value.

Reset
REQ-026 rst=1 SHALL asynchronously clear enable, all digits, acc, idx, result, done and err to 0, and the FSM SHALL enter IDLE.
REQ-027 A reset during CALC SHALL abort the conversion with no done pulse; after release, a fresh start SHALL be required.
REQ-028 d_out SHALL be 0 whenever rst=1.

Verification
REQ-029 Writing digits 9,9,9,9, then enable=1 -> done=1 on the 5th edge after the start edge; reading 0xA returns 16'd9999.
REQ-030 Writing digits 0,0,0,0 and starting -> result 0 and done=1; then writing digits 1,2,0,5, enable=0, enable=1 -> result 16'd1205 and err=0.
REQ-031 Writing uni=4'hC and starting -> done=1 with err=1 and result=0 at the first edge after the start edge.
REQ-032 Writing tho=7 during CALC of 1,2,3,4 -> result 16'd1234, and a later readback of tho returns 1.
REQ-033 Asserting rst for one cycle during the 2nd CALC cycle -> all reads return 0, done stays 0, and there is no spurious result.
REQ-034 Holding enable=1 and writing 1 again after DONE -> no restart and done stays 1; a start occurs only after an enable=0 write followed by an enable=1 write.

Source files
------------

// File: rtl/peripheral_bcd2bin.sv
`timescale 1ns/1ps
// Bus peripheral that converts four BCD digits (tho..uni) to a 16-bit binary result.
// Start on an enable 0->1 write; done 5 edges later (err after 1 edge on a bad digit).
module peripheral_bcd2bin (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic        enable_q;
    logic [3:0]  tho, hun, ten, uni;
    logic [13:0] acc;
    logic [2:0]  idx;
    logic [15:0] result;
    logic        done, err;

    logic        wr_en, busy, start, bad_digit, calc_bad, calc_fin;
    logic [3:0]  digit;
    logic [13:0] acc_mac;
    logic        unused_d_in;

    assign unused_d_in = ^d_in[15:4];

    assign wr_en     = cs & wr;
    assign busy      = (state == CALC);
    assign start     = wr_en & (addr == 4'h0) & d_in[0] & ~enable_q & ~busy;
    assign bad_digit = (tho > 4'd9) | (hun > 4'd9) | (ten > 4'd9) | (uni > 4'd9);
    // Digits are frozen during CALC, so validating on the first CALC edge is exact.
    assign calc_bad  = busy & (idx == 3'd0) & bad_digit;
    assign calc_fin  = busy & (idx == 3'd4);

    always_comb begin
        digit = tho;
        case (idx[1:0])
            2'd0: digit = tho;
            2'd1: digit = hun;
            2'd2: digit = ten;
            2'd3: digit = uni;
            default: digit = tho;
        endcase
    end

    assign acc_mac = (acc << 3) + (acc << 1) + {10'd0, digit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = CALC;
            CALC:       if (calc_bad || calc_fin) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q <= 1'b0;
            tho      <= 4'd0;
            hun      <= 4'd0;
            ten      <= 4'd0;
            uni      <= 4'd0;
            acc      <= 14'd0;
            idx      <= 3'd0;
            result   <= 16'd0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (wr_en && !busy) begin
                case (addr)
                    4'h0: enable_q <= d_in[0];
                    4'h2: tho      <= d_in[3:0];
                    4'h4: hun      <= d_in[3:0];
                    4'h6: ten      <= d_in[3:0];
                    4'h8: uni      <= d_in[3:0];
                    default: ;
                endcase
            end
            if (start) begin
                acc  <= 14'd0;
                idx  <= 3'd0;
                done <= 1'b0;
                err  <= 1'b0;
            end else if (calc_bad) begin
                err    <= 1'b1;
                done   <= 1'b1;
                result <= 16'd0;
            end else if (calc_fin) begin
                result <= {2'b00, acc};
                done   <= 1'b1;
            end else if (busy) begin
                acc <= acc_mac;
                idx <= idx + 3'd1;
            end
        end
    end

    always_comb begin
        d_out = 16'h0000;
        if (cs && rd && !rst) begin
            case (addr)
                4'h2: d_out = {12'd0, tho};
                4'h4: d_out = {12'd0, hun};
                4'h6: d_out = {12'd0, ten};
                4'h8: d_out = {12'd0, uni};
                4'hA: d_out = result;
                4'hC: d_out = {15'd0, done};
                4'hE: d_out = {15'd0, err};
                default: d_out = 16'h0000;
            endcase
        end
    end

endmodule
